// File: rtl/roi_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : roi_window_ctrl
// Brief    : Per-frame foreground bounding-box tracker. Commits the window
//            bounds used by the HV-count windowing stage at each vsync rise,
//            and falls back to full frame after HOLD_FRAMES rejected frames.
//            Optional macro ROI_SMOOTH_EN averages consecutive accepted boxes.
// Revision : 1.0 - initial release
// ============================================================================
module roi_window_ctrl #(
    parameter int IW          = 1024,
    parameter int IH          = 768,
    parameter int MIN_PIX     = 64,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        pixelclk,
    input  logic        reset,
    input  logic        i_binary,
    input  logic        i_de,
    input  logic        i_vsync,
    input  logic [11:0] hcount,
    input  logic [11:0] vcount,
    output logic [11:0] hcount_l1,
    output logic [11:0] hcount_r1,
    output logic [11:0] vcount_l1,
    output logic [11:0] vcount_r1,
    output logic        o_valid,
    output logic        o_frame_done
);

    localparam logic [1:0]  WAIT_VS = 2'd0;
    localparam logic [1:0]  ACCUM   = 2'd1;
    localparam logic [1:0]  COMMIT  = 2'd2;

    localparam logic [12:0] H_LIM    = 13'(IW);
    localparam logic [12:0] V_LIM    = 13'(IH);
    localparam logic [11:0] H_LAST   = 12'(IW - 1);
    localparam logic [11:0] V_LAST   = 12'(IH - 1);
    localparam logic [19:0] MIN_CNT  = 20'(MIN_PIX);
    localparam logic [4:0]  HOLD     = 5'(HOLD_FRAMES);
    localparam logic [19:0] CNT_SAT  = 20'hFFFFF;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic        vs_d;
    logic        frame_edge;
    logic        hit;

    logic [11:0] hmin, hmax, vmin, vmax;
    logic [19:0] cnt;
    logic [3:0]  miss;

    logic        commit;
    logic        accept;
    logic        fallback;
    logic        acc_en;
    logic [3:0]  miss_nxt;
    logic [11:0] base_hmin, base_hmax, base_vmin, base_vmax;
    logic [19:0] base_cnt;
    logic [11:0] hmin_nxt, hmax_nxt, vmin_nxt, vmax_nxt;
    logic [19:0] cnt_nxt;
    logic [11:0] new_hl, new_hr, new_vl, new_vr;
    logic [4:0]  miss_inc;

`ifdef ROI_SMOOTH_EN
    function automatic logic [11:0] avg(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12:1];
    endfunction
`endif

    assign frame_edge = i_vsync & ~vs_d;
    assign hit = i_de & i_binary & ({1'b0, hcount} < H_LIM) & ({1'b0, vcount} < V_LIM);

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state <= WAIT_VS;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_VS: if (frame_edge) next_state = ACCUM;
            ACCUM:   if (frame_edge) next_state = COMMIT;
            COMMIT:  next_state = ACCUM;
            default: next_state = WAIT_VS;
        endcase
    end

    always_comb begin
        commit   = (state == COMMIT);
        acc_en   = (state != WAIT_VS);
        accept   = (cnt >= MIN_CNT);
        miss_inc = {1'b0, miss} + 5'd1;
        fallback = (miss_inc >= HOLD);
        miss_nxt = fallback ? HOLD[3:0] : miss_inc[3:0];

        // The commit-cycle pixel seeds the freshly reinitialised accumulators.
        base_hmin = commit ? 12'hFFF : hmin;
        base_hmax = commit ? 12'h000 : hmax;
        base_vmin = commit ? 12'hFFF : vmin;
        base_vmax = commit ? 12'h000 : vmax;
        base_cnt  = commit ? 20'd0   : cnt;

        hmin_nxt = base_hmin;
        hmax_nxt = base_hmax;
        vmin_nxt = base_vmin;
        vmax_nxt = base_vmax;
        cnt_nxt  = base_cnt;
        if (hit) begin
            if (hcount < base_hmin) hmin_nxt = hcount;
            if (hcount > base_hmax) hmax_nxt = hcount;
            if (vcount < base_vmin) vmin_nxt = vcount;
            if (vcount > base_vmax) vmax_nxt = vcount;
            if (base_cnt != CNT_SAT) cnt_nxt = base_cnt + 20'd1;
        end

`ifdef ROI_SMOOTH_EN
        new_hl = o_valid ? avg(hcount_l1, hmin) : hmin;
        new_hr = o_valid ? avg(hcount_r1, hmax) : hmax;
        new_vl = o_valid ? avg(vcount_l1, vmin) : vmin;
        new_vr = o_valid ? avg(vcount_r1, vmax) : vmax;
`else
        new_hl = hmin;
        new_hr = hmax;
        new_vl = vmin;
        new_vr = vmax;
`endif
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vs_d         <= 1'b0;
            hmin         <= 12'hFFF;
            hmax         <= 12'h000;
            vmin         <= 12'hFFF;
            vmax         <= 12'h000;
            cnt          <= 20'd0;
            miss         <= 4'd0;
            hcount_l1    <= 12'd0;
            hcount_r1    <= H_LAST;
            vcount_l1    <= 12'd0;
            vcount_r1    <= V_LAST;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            vs_d         <= i_vsync;
            o_frame_done <= commit;
            if (acc_en) begin
                hmin <= hmin_nxt;
                hmax <= hmax_nxt;
                vmin <= vmin_nxt;
                vmax <= vmax_nxt;
                cnt  <= cnt_nxt;
            end
            if (commit) begin
                if (accept) begin
                    hcount_l1 <= new_hl;
                    hcount_r1 <= new_hr;
                    vcount_l1 <= new_vl;
                    vcount_r1 <= new_vr;
                    o_valid   <= 1'b1;
                    miss      <= 4'd0;
                end else begin
                    miss <= miss_nxt;
                    if (fallback) begin
                        hcount_l1 <= 12'd0;
                        hcount_r1 <= H_LAST;
                        vcount_l1 <= 12'd0;
                        vcount_r1 <= V_LAST;
                        o_valid   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_roi_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_roi_window_ctrl
// Brief    : Scoreboard bench for roi_window_ctrl with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roi_window_ctrl;

    logic        pixelclk = 1'b0;
    logic        reset    = 1'b1;
    logic        i_binary = 1'b0;
    logic        i_de     = 1'b0;
    logic        i_vsync  = 1'b0;
    logic [11:0] hcount   = 12'd0;
    logic [11:0] vcount   = 12'd0;
    logic [11:0] hcount_l1, hcount_r1, vcount_l1, vcount_r1;
    logic        o_valid, o_frame_done;

`ifdef ROI_SMOOTH_EN
    localparam bit SMOOTH = 1'b1;
`else
    localparam bit SMOOTH = 1'b0;
`endif

    roi_window_ctrl #(.IW(1024), .IH(768), .MIN_PIX(64), .HOLD_FRAMES(4)) dut (
        .pixelclk     (pixelclk),
        .reset        (reset),
        .i_binary     (i_binary),
        .i_de         (i_de),
        .i_vsync      (i_vsync),
        .hcount       (hcount),
        .vcount       (vcount),
        .hcount_l1    (hcount_l1),
        .hcount_r1    (hcount_r1),
        .vcount_l1    (vcount_l1),
        .vcount_r1    (vcount_r1),
        .o_valid      (o_valid),
        .o_frame_done (o_frame_done)
    );

    always #5 pixelclk = ~pixelclk;

    int cyc = 0;
    always @(posedge pixelclk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int hl, hr, vl, vr;
        int v;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    // Reference bounds state kept by the stimulus side.
    int m_hl = 0, m_hr = 1023, m_vl = 0, m_vr = 767, m_v = 0, m_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per frame_done pulse, otherwise bounds must hold.
    initial begin
        exp_t cur;
        exp_t e;
        bit   rs;
        cur = '{cyc: 0, hl: 0, hr: 1023, vl: 0, vr: 767, v: 0};
        while (!done) begin
            @(posedge pixelclk);
            rs = reset;
            #1;
            if (rs) begin
                cur = '{cyc: 0, hl: 0, hr: 1023, vl: 0, vr: 767, v: 0};
                chk("rst_frame_done", int'(o_frame_done), 0);
            end else if (o_frame_done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got pulse expected none (cycle %0d)", cyc);
                    continue;
                end
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                cur = e;
            end
            chk("hcount_l1", int'(hcount_l1), cur.hl);
            chk("hcount_r1", int'(hcount_r1), cur.hr);
            chk("vcount_l1", int'(vcount_l1), cur.vl);
            chk("vcount_r1", int'(vcount_r1), cur.vr);
            chk("o_valid",   int'(o_valid),   cur.v);
        end
    end

    task automatic expect_commit(input int cnt, input int hl, input int hr,
                                 input int vl, input int vr, input int k);
        exp_t e;
        if (cnt >= 64) begin
            if (SMOOTH && m_v == 1) begin
                m_hl = (m_hl + hl) / 2;
                m_hr = (m_hr + hr) / 2;
                m_vl = (m_vl + vl) / 2;
                m_vr = (m_vr + vr) / 2;
            end else begin
                m_hl = hl; m_hr = hr; m_vl = vl; m_vr = vr;
            end
            m_v = 1;
            m_miss = 0;
        end else begin
            m_miss = (m_miss + 1 >= 4) ? 4 : m_miss + 1;
            if (m_miss == 4) begin
                m_hl = 0; m_hr = 1023; m_vl = 0; m_vr = 767; m_v = 0;
            end
        end
        e = '{cyc: k + 2, hl: m_hl, hr: m_hr, vl: m_vl, vr: m_vr, v: m_v};
        q.push_back(e);
    endtask

    task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic b, input logic de);
        @(negedge pixelclk);
        hcount   = h;
        vcount   = v;
        i_binary = b;
        i_de     = de;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(12'd0, 12'd0, 1'b0, 1'b0);
    endtask

    task automatic block(input int h0, input int h1, input int v0, input int v1);
        for (int v = v0; v <= v1; v++)
            for (int h = h0; h <= h1; h++)
                pix(12'(h), 12'(v), 1'b1, 1'b1);
        idle(2);
    endtask

    // 64 hits whose box is (l,r,t,b): two corners plus repeats of the first.
    task automatic box_pts(input int l, input int r, input int t, input int b);
        pix(12'(l), 12'(t), 1'b1, 1'b1);
        pix(12'(r), 12'(b), 1'b1, 1'b1);
        for (int i = 0; i < 62; i++) pix(12'(l), 12'(t), 1'b1, 1'b1);
        idle(2);
    endtask

    // vsync high for three cycles; optionally a foreground pixel in the commit cycle.
    task automatic vs_pulse(input bit seed, input bit exp_c, input int cnt,
                            input int hl, input int hr, input int vl, input int vr);
        @(negedge pixelclk);
        i_de    = 1'b0;
        i_vsync = 1'b1;
        if (exp_c) expect_commit(cnt, hl, hr, vl, vr, cyc);
        if (seed) pix(12'd10, 12'd10, 1'b1, 1'b1);
        else      pix(12'd0, 12'd0, 1'b0, 1'b0);
        pix(12'd0, 12'd0, 1'b0, 1'b0);
        @(negedge pixelclk);
        i_vsync = 1'b0;
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge pixelclk);
        reset = 1'b1;
        i_de  = 1'b0;
        @(negedge pixelclk);
        reset = 1'b0;
        m_hl = 0; m_hr = 1023; m_vl = 0; m_vr = 767; m_v = 0; m_miss = 0;
    endtask

    initial begin
        repeat (3) @(negedge pixelclk);
        reset = 1'b0;

        // Partial first frame is discarded; second frame commits the block.
        block(200, 299, 300, 349);
        vs_pulse(0, 0, 0, 0, 0, 0, 0);
        block(200, 299, 300, 349);
        vs_pulse(0, 1, 5000, 200, 299, 300, 349);

        // 63 pixels rejected (bounds hold), then 64 accepted.
        for (int h = 0; h < 63; h++) pix(12'(h), 12'd10, 1'b1, 1'b1);
        idle(2);
        vs_pulse(0, 1, 63, 0, 0, 0, 0);
        for (int h = 0; h < 64; h++) pix(12'(h), 12'd20, 1'b1, 1'b1);
        idle(2);
        vs_pulse(0, 1, 64, 0, 63, 20, 20);

        // Four empty frames: hold through three, full-frame fallback on the fourth.
        for (int f = 0; f < 4; f++) begin
            idle(5);
            vs_pulse(0, 1, 0, 0, 0, 0, 0);
        end

        // Out-of-range foreground pixels do not affect the box.
        pix(12'd1030, 12'd5, 1'b1, 1'b1);
        pix(12'd5, 12'd800, 1'b1, 1'b1);
        pix(12'd1024, 12'd768, 1'b1, 1'b1);
        block(400, 407, 100, 107);
        vs_pulse(1, 1, 64, 400, 407, 100, 107);

        // Commit-cycle pixel at (10,10) seeds the next frame's box.
        block(500, 510, 500, 510);
        vs_pulse(0, 1, 122, 10, 510, 10, 510);

        // Two consecutive boxes (averaged when smoothing is built in).
        box_pts(100, 200, 100, 200);
        vs_pulse(0, 1, 64, 100, 200, 100, 200);
        box_pts(201, 301, 201, 301);
        vs_pulse(0, 1, 64, 201, 301, 201, 301);

        // Mid-frame reset: defaults next cycle, partial frame not committed.
        box_pts(600, 700, 600, 700);
        do_reset();
        box_pts(600, 700, 600, 700);
        vs_pulse(0, 0, 0, 0, 0, 0, 0);
        box_pts(50, 60, 70, 80);
        vs_pulse(0, 1, 64, 50, 60, 70, 80);

        idle(6);
        chk("queue_empty", q.size(), 0);
        done = 1'b1;
        @(posedge pixelclk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/roi_window_ctrl.md
# roi_window_ctrl

Per-frame region-of-interest controller for the fruit-recognition ISP chain. It accumulates the bounding box of foreground pixels from the binary mask over one frame. At each frame boundary it commits that box as the window bounds (hcount_l1/hcount_r1/vcount_l1/vcount_r1) consumed by the HV-count windowing stage. Frames with too few foreground pixels are rejected, and after a run of misses the window falls back to full frame.

## Interface
Parameters:
- IW, 1024, active pixels per line; hcount values >= IW are ignored.
- IH, 768, active lines per frame; vcount values >= IH are ignored.
- MIN_PIX, 64, minimum foreground pixel count for a frame to be accepted.
- HOLD_FRAMES, 4, consecutive rejected frames before fallback to full frame (1..15).

Ports:
- pixelclk  in  1  pixel clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- i_binary  in  1  binary mask pixel; 1 = foreground.
- i_de  in  1  data enable; pixel is valid when high.
- i_vsync  in  1  vertical sync; its rising edge marks the frame boundary.
- hcount  in  12  pixel column from the HV-count stage.
- vcount  in  12  line index from the HV-count stage.
- hcount_l1  out  12  committed window left bound.
- hcount_r1  out  12  committed window right bound.
- vcount_l1  out  12  committed window top bound.
- vcount_r1  out  12  committed window bottom bound.
- o_valid  out  1  high while the committed bounds come from a detected object.
- o_frame_done  out  1  one-cycle pulse in the commit cycle.

## Operation
- Edge detect: vs_d registers i_vsync every cycle. A frame edge is i_vsync=1 && vs_d=0.
- The FSM has three states:
  - WAIT_VS (reset state): accumulators are idle and pixels are ignored. A frame edge moves to ACCUM. The partial first frame is discarded.
  - ACCUM: a hit is i_de && i_binary && hcount<IW && vcount<IH. On a hit:
    - hmin = min(hmin, hcount) and hmax = max(hmax, hcount).
    - vmin and vmax update the same way from vcount.
    - cnt increments, saturating at 2^20-1.
    - A frame edge moves to COMMIT.
  - COMMIT (exactly one cycle, then back to ACCUM):
    - Accept when cnt >= MIN_PIX: bounds <= (hmin, hmax, vmin, vmax), o_valid <= 1, miss <= 0.
    - Reject otherwise: miss <= miss+1, saturating at HOLD_FRAMES. If miss+1 >= HOLD_FRAMES, bounds <= (0, IW-1, 0, IH-1) and o_valid <= 0. Otherwise bounds and o_valid hold.
    - Accumulators reinit: hmin = vmin = 12'hFFF, hmax = vmax = 0, cnt = 0.
    - A hit in the COMMIT cycle seeds the new accumulators (reinit, then merge that pixel). It is not lost.
- A frame edge in WAIT_VS or COMMIT never triggers a second commit. In practice vsync high lasts more than 1 cycle, so no edge recurs.
- The accept test uses the count value before the COMMIT-cycle pixel is merged.

## Timing
- Reset values:
  - Outputs: hcount_l1 = 0, hcount_r1 = IW-1, vcount_l1 = 0, vcount_r1 = IH-1, o_valid = 0, o_frame_done = 0.
  - Internal: state = WAIT_VS, miss = 0, vs_d = 0, accumulators reinit.
- Latency:
  - Rising edge of i_vsync sampled at clock edge N: state = COMMIT after N.
  - Bounds, o_valid and o_frame_done are updated after edge N+1. They are visible from N+1 until the next commit.
- Bounds never change outside the COMMIT cycle, so the windowing stage sees stable bounds for the whole frame.
- Reset asserted mid-frame takes priority over everything. Outputs return to reset values on the next clock edge, and the in-progress frame is discarded.
- Widths:
  - Comparisons are 12-bit unsigned.
  - cnt is 20 bits, compared against MIN_PIX zero-extended.

## Configuration
- ROI_SMOOTH_EN defined: on accept with o_valid already 1, each bound <= (old + new) >> 1.
  - The sum is computed at 13 bits, so there is no overflow.
  - Truncation rounds toward zero.
  - On accept with o_valid = 0, bounds load directly.
- ROI_SMOOTH_EN undefined: accepted bounds always load directly. No averaging logic is built.

## Test plan
- Reset, then two frames, each with a 100x50 foreground block at h 200..299, v 300..349 -> no commit after the first edge (WAIT_VS). After the second edge, bounds = 200/299/300/349, o_valid = 1, one o_frame_done pulse 2 cycles after the vsync rise.
- Accepted frame, then 4 empty frames (HOLD_FRAMES=4) -> bounds hold through rejected frames 1-3. After the 4th: bounds = 0/1023/0/767, o_valid = 0.
- Exactly 63 vs 64 foreground pixels (MIN_PIX=64) -> 63 rejected (miss increments), 64 accepted.
- Foreground pixel at hcount=1030 or vcount=800 plus a valid block -> out-of-range pixels excluded from bounds and count.
- Foreground pixel with i_de=1 in the COMMIT cycle at (10,10), rest of frame a block at 500..510 -> next commit bounds = 10/510/10/510 (block spans the same range vertically).
- ROI_SMOOTH_EN: accepted box 100/200/100/200, then 201/301/201/301 -> bounds 150/250/150/250.
- Reset mid-frame -> defaults next cycle; first partial frame after reset not committed.
